// File: rtl/lastfrog_pkg.sv
// Shared game-state definitions for the frog game: state encodings, lives
// sizing and small lives helpers used by the lives manager and the display.
package lastfrog_pkg;

  localparam int MAX_LIVES = 3;
  localparam int LIVES_W   = 2;
  localparam int CNT_W     = 7;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    DYING     = 3'd2,
    INVULN    = 3'd3,
    GAME_OVER = 3'd4
  } state_t;

  // Lives decrement that sticks at zero instead of wrapping.
  function automatic logic [LIVES_W-1:0] lives_dec_sat(input logic [LIVES_W-1:0] l);
    return (l == '0) ? '0 : l - 1'b1;
  endfunction

  // Clamp an integer life count into 0..MAX_LIVES.
  function automatic logic [LIVES_W-1:0] lives_clamp(input int n);
    if (n > MAX_LIVES) return LIVES_W'(MAX_LIVES);
    if (n < 0)         return '0;
    return LIVES_W'(n);
  endfunction

endpackage

// File: rtl/frame_countdown.sv
// Loadable frame down-counter shared by the death pause and the
// invulnerability window. Advances once per frame_tick while enabled and
// stops at zero. count_next is the value the counter holds after this edge,
// so registered outputs derived from it line up with the stored count.
module frame_countdown
  import lastfrog_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count_next,
  output logic             last
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: a load takes priority over the per-frame decrement.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && tick && (count_q != '0)) begin
      count_d = count_q - 1'b1;
    end
  end

  // Count register; reset aborts any countdown in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_next = count_d;
  assign last       = tick && (count_q == CNT_W'(1));

endmodule

// File: rtl/lives_manager.sv
// Frog lives bookkeeping: accumulates collisions over each frame, removes at
// most one life per frame, and sequences death pause, respawn, blinking
// invulnerability and game over. All outputs are registered.
module lives_manager
  import lastfrog_pkg::*;
#(
  parameter int START_LIVES   = 3,
  parameter int DEATH_FRAMES  = 30,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_SHIFT   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               collision,
  input  logic               start,
  output logic [LIVES_W-1:0] lives,
  output logic               game_over,
  output logic               frog_freeze,
  output logic               frog_visible,
  output logic               respawn,
  output logic [2:0]         state_dbg
);

  localparam logic [LIVES_W-1:0] START_L  = lives_clamp(START_LIVES);
  localparam logic [CNT_W-1:0]   DEATH_L  = CNT_W'(DEATH_FRAMES);
  localparam logic [CNT_W-1:0]   INVULN_L = CNT_W'(INVULN_FRAMES);

  state_t             state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic               hit_flag_q, hit_flag_d;
  logic               game_over_q, game_over_d;
  logic               frog_freeze_q, frog_freeze_d;
  logic               frog_visible_q, frog_visible_d;
  logic               respawn_q, respawn_d;

  logic               cnt_en;
  logic               cnt_load;
  logic [CNT_W-1:0]   cnt_load_val;
  logic [CNT_W-1:0]   cnt_next;
  logic               cnt_last;

  frame_countdown u_countdown (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (cnt_en),
    .tick       (frame_tick),
    .load       (cnt_load),
    .load_val   (cnt_load_val),
    .count_next (cnt_next),
    .last       (cnt_last)
  );

  // Next-state, lives, hit accumulation and registered-output values.
  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    respawn_d    = 1'b0;
    cnt_en       = 1'b0;
    cnt_load     = 1'b0;
    cnt_load_val = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = PLAY;
          lives_d   = START_L;
          respawn_d = 1'b1;
        end
      end
      PLAY: begin
        // A collision on the tick cycle itself still counts for this frame.
        if (frame_tick && (hit_flag_q || collision)) begin
          if (lives_q > LIVES_W'(1)) begin
            lives_d      = lives_dec_sat(lives_q);
            state_d      = DYING;
            cnt_load     = 1'b1;
            cnt_load_val = DEATH_L;
          end else begin
            lives_d = '0;
            state_d = GAME_OVER;
          end
        end
      end
      DYING: begin
        cnt_en = 1'b1;
        if (cnt_last) begin
          state_d      = INVULN;
          cnt_load     = 1'b1;
          cnt_load_val = INVULN_L;
          respawn_d    = 1'b1;
        end
      end
      INVULN: begin
        cnt_en = 1'b1;
        if (cnt_last) state_d = PLAY;
      end
      GAME_OVER: begin
        lives_d = '0;
        if (start) begin
          state_d   = PLAY;
          lives_d   = START_L;
          respawn_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Hits only accumulate in PLAY and never carry across a frame or a state change.
    if (frame_tick || (state_d != state_q)) begin
      hit_flag_d = 1'b0;
    end else if ((state_q == PLAY) && collision) begin
      hit_flag_d = 1'b1;
    end else begin
      hit_flag_d = hit_flag_q;
    end

    game_over_d    = (state_d == GAME_OVER);
    frog_freeze_d  = (state_d == IDLE) || (state_d == DYING) || (state_d == GAME_OVER);
    frog_visible_d = (state_d == INVULN) ? ~cnt_next[BLINK_SHIFT] : 1'b1;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      lives_q        <= START_L;
      hit_flag_q     <= 1'b0;
      game_over_q    <= 1'b0;
      frog_freeze_q  <= 1'b1;
      frog_visible_q <= 1'b1;
      respawn_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      lives_q        <= lives_d;
      hit_flag_q     <= hit_flag_d;
      game_over_q    <= game_over_d;
      frog_freeze_q  <= frog_freeze_d;
      frog_visible_q <= frog_visible_d;
      respawn_q      <= respawn_d;
    end
  end

  assign lives        = lives_q;
  assign game_over    = game_over_q;
  assign frog_freeze  = frog_freeze_q;
  assign frog_visible = frog_visible_q;
  assign respawn      = respawn_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_lives_manager.sv
// Self-checking bench for lives_manager: directed scenarios plus a random
// phase, compared every cycle against a frame-level reference model.
module tb_lives_manager;

  localparam int START_LIVES   = 3;
  localparam int DEATH_FRAMES  = 30;
  localparam int INVULN_FRAMES = 60;
  localparam int BLINK_SHIFT   = 3;

  localparam int S_IDLE = 0, S_PLAY = 1, S_DYING = 2, S_INVULN = 3, S_OVER = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_tick;
  logic       collision;
  logic       start;
  logic [1:0] lives;
  logic       game_over;
  logic       frog_freeze;
  logic       frog_visible;
  logic       respawn;
  logic [2:0] state_dbg;

  int errors = 0;
  int checks = 0;

  // Reference model: game phase, lives, frames remaining in the current
  // timed phase, whether this frame has already seen a hit, respawn pulse.
  int m_state;
  int m_lives;
  int m_frames_left;
  bit m_hit;
  bit m_resp;

  always #5 clk = ~clk;

  lives_manager #(
    .START_LIVES   (START_LIVES),
    .DEATH_FRAMES  (DEATH_FRAMES),
    .INVULN_FRAMES (INVULN_FRAMES),
    .BLINK_SHIFT   (BLINK_SHIFT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_tick   (frame_tick),
    .collision    (collision),
    .start        (start),
    .lives        (lives),
    .game_over    (game_over),
    .frog_freeze  (frog_freeze),
    .frog_visible (frog_visible),
    .respawn      (respawn),
    .state_dbg    (state_dbg)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state       = S_IDLE;
    m_lives       = START_LIVES;
    m_frames_left = 0;
    m_hit         = 1'b0;
    m_resp        = 1'b0;
  endtask

  // One clock of game rules, evaluated with the inputs present before the edge.
  task automatic model_step(input bit s, input bit t, input bit c);
    int prev = m_state;
    m_resp = 1'b0;
    if ((m_state == S_IDLE || m_state == S_OVER) && s) begin
      m_state = S_PLAY;
      m_lives = START_LIVES;
      m_resp  = 1'b1;
    end else if (m_state == S_PLAY && t && (m_hit || c)) begin
      m_lives = m_lives - 1;
      if (m_lives > 0) begin
        m_state       = S_DYING;
        m_frames_left = DEATH_FRAMES;
      end else begin
        m_state = S_OVER;
      end
    end else if (m_state == S_DYING && t) begin
      if (m_frames_left == 1) begin
        m_state       = S_INVULN;
        m_frames_left = INVULN_FRAMES;
        m_resp        = 1'b1;
      end else begin
        m_frames_left--;
      end
    end else if (m_state == S_INVULN && t) begin
      if (m_frames_left == 1) m_state = S_PLAY;
      m_frames_left--;
    end
    if (t || m_state != prev) m_hit = 1'b0;
    else if (prev == S_PLAY && c) m_hit = 1'b1;
  endtask

  task automatic check_all(input string ctx);
    bit exp_vis;
    exp_vis = (m_state == S_INVULN) ? (((m_frames_left / (1 << BLINK_SHIFT)) % 2) == 0) : 1'b1;
    check({ctx, "/lives"},     32'(lives),        32'(m_lives));
    check({ctx, "/state"},     32'(state_dbg),    32'(m_state));
    check({ctx, "/game_over"}, 32'(game_over),    32'(m_state == S_OVER));
    check({ctx, "/freeze"},    32'(frog_freeze),  32'(m_state == S_IDLE || m_state == S_DYING || m_state == S_OVER));
    check({ctx, "/visible"},   32'(frog_visible), 32'(exp_vis));
    check({ctx, "/respawn"},   32'(respawn),      32'(m_resp));
  endtask

  // Drive one cycle of inputs, let the edge happen, then compare.
  task automatic step(input bit s, input bit t, input bit c, input string ctx);
    start      = s;
    frame_tick = t;
    collision  = c;
    @(posedge clk);
    model_step(s, t, c);
    #1;
    start      = 1'b0;
    frame_tick = 1'b0;
    collision  = 1'b0;
    check_all(ctx);
  endtask

  // A four-cycle frame; start is poked randomly only where it must be ignored.
  task automatic run_frame(input bit c, input string ctx);
    for (int k = 0; k < 3; k++) begin
      bit s;
      s = (m_state == S_DYING || m_state == S_INVULN) ? ($urandom_range(0, 4) == 0) : 1'b0;
      step(s, 1'b0, c, ctx);
    end
    step(1'b0, 1'b1, c, ctx);
  endtask

  initial begin
    rst_n      = 1'b1;
    start      = 1'b0;
    frame_tick = 1'b0;
    collision  = 1'b0;
    model_reset();

    // Power-on reset, checked before any clock edge
    #1 rst_n = 1'b0;
    #1 check_all("reset");
    @(posedge clk);
    #1 check_all("reset_held");
    #2 rst_n = 1'b1;

    // Idle, then start
    step(1'b0, 1'b0, 1'b0, "idle");
    step(1'b0, 1'b1, 1'b0, "idle_tick");
    step(1'b1, 1'b0, 1'b0, "start");
    check("start_freeze_low", 32'(frog_freeze), 32'(0));
    step(1'b0, 1'b0, 1'b0, "post_start");
    run_frame(1'b0, "play_clean");
    run_frame(1'b0, "play_clean");

    // Five collision cycles within one frame cost exactly one life
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, "coll_burst");
    step(1'b0, 1'b0, 1'b0, "coll_gap");
    step(1'b0, 1'b1, 1'b0, "hit_tick");
    check("hit_lives2", 32'(lives), 32'(2));

    // Death pause with random collision noise, then respawn into INVULN
    for (int i = 0; i < DEATH_FRAMES; i++) run_frame(1'($urandom_range(0, 1)), "dying");
    check("dying_done_state", 32'(state_dbg), 32'(S_INVULN));

    // Invulnerable window with collision held high
    for (int i = 0; i < INVULN_FRAMES; i++) run_frame(1'b1, "invuln");
    check("invuln_done_state", 32'(state_dbg), 32'(S_PLAY));

    // Collision only on the tick cycle, hit flag clear
    run_frame(1'b0, "play_clean2");
    step(1'b0, 1'b1, 1'b1, "coll_on_tick");
    check("coll_on_tick_lives1", 32'(lives), 32'(1));

    // Last life: run out the pause and grace, then final hit
    for (int i = 0; i < DEATH_FRAMES + INVULN_FRAMES; i++) run_frame(1'b1, "second_death");
    step(1'b0, 1'b0, 1'b1, "final_coll");
    step(1'b0, 1'b1, 1'b0, "final_tick");
    check("game_over_lives0", 32'(lives), 32'(0));
    run_frame(1'b1, "over_wait");
    step(1'b1, 1'b1, 1'b0, "start_beats_tick");
    step(1'b0, 1'b0, 1'b0, "restart_settle");

    // Random play
    for (int i = 0; i < 1500; i++) begin
      step(1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) == 0),
           1'($urandom_range(0, 5) == 0), "random");
    end

    // Asynchronous reset partway through a death pause
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("rst_random");
    #2 rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b0, "restart2");
    step(1'b0, 1'b1, 1'b1, "hit_for_rst");
    for (int i = 0; i < DEATH_FRAMES - 12; i++) run_frame(1'b0, "dying_to12");
    check("dying_cnt12_state", 32'(state_dbg), 32'(S_DYING));
    check("dying_cnt12_model", 32'(m_frames_left), 32'(12));
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all("async_rst_dying");
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check_all("start_during_rst");
    #2 rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0, "rst_release");
    step(1'b1, 1'b0, 1'b0, "start_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
